// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational MULTIPLIER_N_BIT between two requesters
//   (port 0: ALU issue path, port 1: address-generation path).
//   Round-robin arbitration in IDLE. The winner's operands are registered,
//   the product is captured one cycle later, and the result is held until
//   the owner acknowledges it.
//
// Optional feature macro: MULT_SHARE_ARBITER_TIMEOUT_EN
//   When defined, an unacknowledged result is dropped after TIMEOUT DONE
//   cycles and timeout_err pulses. When undefined, DONE waits for the ack
//   indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clk, reset_n          rising-edge clock, synchronous active-low reset
//   req0/a0/b0/ack0       requester 0 request, operands, result acknowledge
//   req1/a1/b1/ack1       requester 1 request, operands, result acknowledge
//   grant0/grant1         one-cycle pulse: that requester's operands captured
//   done0/done1           result valid for that requester
//   result, cout          low N bits of product, overflow (shared, held)
//   busy                  high whenever the arbiter is not in IDLE
//   timeout_err           one-cycle pulse when a result is dropped
//
// Handshake: req and operands are held by the requester until grant; done
// stays high until the owner's ack is sampled in DONE. The non-owner's ack
// is ignored. req is level-sensitive and only sampled in IDLE.

module MULTIPLIER_N_BIT #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         cout
);
  logic [2*N-1:0] prod;

  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign out  = prod[N-1:0];
  assign cout = |prod[2*N-1:N];
endmodule

module mult_share_arbiter #(
  parameter int N       = 7,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         ack0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         ack1,
  output logic         grant0,
  output logic         grant1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         busy,
  output logic         timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mult_share_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic         last;    // port served most recently; loses the next tie
  logic         owner;   // port that owns the job in flight
  logic         win;
  logic         owner_ack;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] mul_out;
  logic         mul_cout;

  MULTIPLIER_N_BIT #(.N(N)) u_mult (
    .a    (op_a),
    .b    (op_b),
    .out  (mul_out),
    .cout (mul_cout)
  );

  // Single request wins outright; on a tie the port that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~last;
    else if (req1)    win = 1'b1;
  end

  assign owner_ack = owner ? ack1 : ack0;

`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner  <= win;
            op_a   <= win ? a1 : a0;
            op_b   <= win ? b1 : b0;
            grant0 <= ~win;
            grant1 <= win;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          result <= mul_out;
          cout   <= mul_cout;
          done0  <= ~owner;
          done1  <= owner;
          state  <= DONE;
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
          cnt    <= '0;
`endif
        end
        DONE: begin
          // An ack in the same cycle as the timeout takes priority.
          if (owner_ack) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            last  <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef MULT_SHARE_ARBITER_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            last        <= owner;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
